// File: rtl/interval_timer_avmm_master.sv
// Avalon-MM initiator that programs an interval timer and services its
// timeouts: writes period and control, clears status, snapshots and reads back.
module interval_timer_avmm_master #(
  parameter logic [3:0] CTRL_RUN  = 4'h7,
  parameter logic [3:0] CTRL_STOP = 4'h8,
  parameter int         TICK_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [31:0]       period,
  input  logic              irq_in,
  output logic [2:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [15:0]       avm_writedata,
  input  logic [15:0]       avm_readdata,
  output logic              busy,
  output logic              running,
  output logic              tick_valid,
  output logic [31:0]       tick_snapshot,
  output logic [TICK_W-1:0] tick_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_ARMED, S_CLR_TO,
    S_SNAP, S_RD_SL, S_W_SL, S_RD_SH, S_W_SH, S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         period_q, period_d;
  logic                stop_pend_q, stop_pend_d;
  logic                running_q, running_d;
  logic                tick_valid_q, tick_valid_d;
  logic [31:0]         snapshot_q, snapshot_d;
  logic [15:0]         snap_l_q, snap_l_d;
  logic [TICK_W-1:0]   count_q, count_d;
  logic                cs_q, cs_d;
  logic                wn_q, wn_d;
  logic [2:0]          addr_q, addr_d;
  logic [15:0]         wd_q, wd_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    running_d    = running_q;
    tick_valid_d = 1'b0;
    snapshot_d   = snapshot_q;
    snap_l_d     = snap_l_q;
    count_d      = count_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_WR_PL;
          period_d = period;
          count_d  = '0;
        end
      end
      S_WR_PL:   state_d = S_WR_PH;
      S_WR_PH:   state_d = S_WR_CTRL;
      S_WR_CTRL: begin
        running_d = 1'b1;
        state_d   = (stop_pend_q || stop) ? S_STOP : S_ARMED;
      end
      S_ARMED: begin
        if (stop)        state_d = S_STOP;
        else if (irq_in) state_d = S_CLR_TO;
      end
      S_CLR_TO:  state_d = S_SNAP;
      S_SNAP:    state_d = S_RD_SL;
      S_RD_SL:   state_d = S_W_SL;
      S_W_SL: begin
        snap_l_d = avm_readdata;
        state_d  = S_RD_SH;
      end
      S_RD_SH:   state_d = S_W_SH;
      S_W_SH: begin
        snapshot_d   = {avm_readdata, snap_l_q};
        tick_valid_d = 1'b1;
        count_d      = count_q + TICK_W'(1);
        state_d      = (stop_pend_q || stop) ? S_STOP : S_ARMED;
      end
      S_STOP: begin
        running_d = 1'b0;
        state_d   = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // IDLE and ARMED act on stop directly; elsewhere it waits for the next exit point.
  always_comb begin
    stop_pend_d = stop_pend_q;
    if (state_q == S_STOP)
      stop_pend_d = 1'b0;
    else if (stop && state_q != S_IDLE && state_q != S_ARMED)
      stop_pend_d = 1'b1;
  end

  // Bus signals are decoded from the next state so the registered outputs
  // carry each state's access during that state's own cycle.
  always_comb begin
    cs_d   = 1'b0;
    wn_d   = 1'b1;
    addr_d = 3'd0;
    wd_d   = 16'h0000;
    case (state_d)
      S_WR_PL:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wd_d = period_d[15:0];  end
      S_WR_PH:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wd_d = period_d[31:16]; end
      S_WR_CTRL: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = {12'h000, CTRL_RUN};  end
      S_CLR_TO:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; end
      S_SNAP:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4; end
      S_RD_SL:   begin cs_d = 1'b1; addr_d = 3'd4; end
      S_RD_SH:   begin cs_d = 1'b1; addr_d = 3'd5; end
      S_STOP:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = {12'h000, CTRL_STOP}; end
      default:   ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      period_q     <= '0;
      stop_pend_q  <= 1'b0;
      running_q    <= 1'b0;
      tick_valid_q <= 1'b0;
      snapshot_q   <= '0;
      snap_l_q     <= '0;
      count_q      <= '0;
      cs_q         <= 1'b0;
      wn_q         <= 1'b1;
      addr_q       <= 3'd0;
      wd_q         <= 16'h0000;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      stop_pend_q  <= stop_pend_d;
      running_q    <= running_d;
      tick_valid_q <= tick_valid_d;
      snapshot_q   <= snapshot_d;
      snap_l_q     <= snap_l_d;
      count_q      <= count_d;
      cs_q         <= cs_d;
      wn_q         <= wn_d;
      addr_q       <= addr_d;
      wd_q         <= wd_d;
    end
  end

  assign avm_chipselect = cs_q;
  assign avm_write_n    = wn_q;
  assign avm_address    = addr_q;
  assign avm_writedata  = wd_q;
  assign busy           = (state_q != S_IDLE);
  assign running        = running_q;
  assign tick_valid     = tick_valid_q;
  assign tick_snapshot  = snapshot_q;
  assign tick_count     = count_q;

endmodule

// File: tb/tb_interval_timer_avmm_master.sv
// Directed bench for interval_timer_avmm_master with a small timer-slave read
// model; outputs are sampled on the falling clock edge.
module tb_interval_timer_avmm_master;

  localparam int TICK_W = 2;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              stop;
  logic [31:0]       period;
  logic              irq_in;
  logic [2:0]        avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic [15:0]       avm_writedata;
  logic [15:0]       avm_readdata;
  logic              busy;
  logic              running;
  logic              tick_valid;
  logic [31:0]       tick_snapshot;
  logic [TICK_W-1:0] tick_count;

  logic [15:0] snap_l_v;
  logic [15:0] snap_h_v;

  int n_checks = 0;
  int n_fail   = 0;

  interval_timer_avmm_master #(.TICK_W(TICK_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .stop           (stop),
    .period         (period),
    .irq_in         (irq_in),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .busy           (busy),
    .running        (running),
    .tick_valid     (tick_valid),
    .tick_snapshot  (tick_snapshot),
    .tick_count     (tick_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer slave: read data appears one cycle after the read address.
  always @(posedge clk) begin
    if (avm_chipselect && avm_write_n)
      avm_readdata <= (avm_address == 3'd4) ? snap_l_v :
                      (avm_address == 3'd5) ? snap_h_v : 16'hDEAD;
    else
      avm_readdata <= 16'h0000;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bus(input logic cs, input logic wn,
                                      input logic [2:0] a, input logic [15:0] wd);
    return {11'b0, cs, wn, a, wd};
  endfunction

  function automatic logic [31:0] bus_now();
    return {11'b0, avm_chipselect, avm_write_n, avm_address, avm_writedata};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // From an ARMED negedge: raise irq, run the 7-cycle service, check the result.
  task automatic service(input string tag, input logic [15:0] lo, input logic [15:0] hi,
                         input logic [TICK_W-1:0] exp_count);
    snap_l_v = lo;
    snap_h_v = hi;
    irq_in   = 1'b1;
    step(1);
    irq_in   = 1'b0;
    step(6);
    check({tag, "_valid"}, {31'b0, tick_valid}, 32'd1);
    check({tag, "_snap"}, tick_snapshot, {hi, lo});
    check({tag, "_count"}, {30'b0, tick_count}, {30'b0, exp_count});
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    period   = 32'h0;
    irq_in   = 1'b0;
    snap_l_v = 16'h0;
    snap_h_v = 16'h0;
    avm_readdata = 16'h0;
    step(3);

    // Reset state
    check("rst_bus", bus_now(), bus(1'b0, 1'b1, 3'd0, 16'h0000));
    check("rst_flags", {29'b0, busy, running, tick_valid}, 32'd0);
    check("rst_snap", tick_snapshot, 32'd0);
    check("rst_count", {30'b0, tick_count}, 32'd0);
    reset_n = 1'b1;
    step(1);

    // 1: program period, three back-to-back writes
    start  = 1'b1;
    period = 32'h00BE_BC1F;
    step(1);
    start  = 1'b0;
    check("t1_wr_pl", bus_now(), bus(1'b1, 1'b0, 3'd2, 16'hBC1F));
    check("t1_busy", {31'b0, busy}, 32'd1);
    step(1);
    check("t1_wr_ph", bus_now(), bus(1'b1, 1'b0, 3'd3, 16'h00BE));
    step(1);
    check("t1_wr_ctrl", bus_now(), bus(1'b1, 1'b0, 3'd1, 16'h0007));
    step(1);
    check("t1_armed_cs", {31'b0, avm_chipselect}, 32'd0);
    check("t1_running", {31'b0, running}, 32'd1);

    // 2: one serviced timeout, cycle by cycle
    snap_l_v = 16'h1234;
    snap_h_v = 16'h0056;
    irq_in   = 1'b1;
    step(1);
    irq_in   = 1'b0;
    check("t2_clr", bus_now(), bus(1'b1, 1'b0, 3'd0, 16'h0000));
    step(1);
    check("t2_snap_trig", bus_now(), bus(1'b1, 1'b0, 3'd4, 16'h0000));
    step(1);
    check("t2_rd_sl", {29'b0, avm_chipselect, avm_write_n, 1'b0} | {29'b0, avm_address}, 32'h0000_0006 | 32'd4);
    check("t2_rd_sl_addr", {29'b0, avm_address}, 32'd4);
    step(1);
    check("t2_w_sl_cs", {31'b0, avm_chipselect}, 32'd0);
    step(1);
    check("t2_rd_sh", {29'b0, avm_address}, 32'd5);
    check("t2_rd_sh_ctl", {30'b0, avm_chipselect, avm_write_n}, 32'd3);
    step(1);
    check("t2_w_sh_cs", {31'b0, avm_chipselect}, 32'd0);
    check("t2_not_yet", {31'b0, tick_valid}, 32'd0);
    step(1);
    check("t2_valid", {31'b0, tick_valid}, 32'd1);
    check("t2_snapshot", tick_snapshot, 32'h0056_1234);
    check("t2_count", {30'b0, tick_count}, 32'd1);
    step(1);
    check("t2_pulse_end", {31'b0, tick_valid}, 32'd0);

    // 3: stop and irq together in ARMED -> stop wins
    stop   = 1'b1;
    irq_in = 1'b1;
    step(1);
    stop   = 1'b0;
    irq_in = 1'b0;
    check("t3_wr_stop", bus_now(), bus(1'b1, 1'b0, 3'd1, 16'h0008));
    step(1);
    check("t3_idle", {30'b0, busy, running}, 32'd0);
    check("t3_no_svc", {31'b0, tick_valid}, 32'd0);

    // 5 (with start beating stop in IDLE): restart, spurious start in WR_PH
    start  = 1'b1;
    stop   = 1'b1;
    period = 32'h0000_0010;
    step(1);
    start  = 1'b0;
    stop   = 1'b0;
    period = 32'hFFFF_FFFF;
    check("t5_wr_pl", bus_now(), bus(1'b1, 1'b0, 3'd2, 16'h0010));
    check("t5_count_clr", {30'b0, tick_count}, 32'd0);
    step(1);
    check("t5_wr_ph", bus_now(), bus(1'b1, 1'b0, 3'd3, 16'h0000));
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("t5_wr_ctrl", bus_now(), bus(1'b1, 1'b0, 3'd1, 16'h0007));
    step(1);
    check("t5_armed", {30'b0, avm_chipselect, busy}, 32'd1);
    step(1);
    check("t5_no_rewrite", {30'b0, avm_chipselect, running}, 32'd1);

    // 4: stop during RD_SL is held until the service completes
    snap_l_v = 16'hAAAA;
    snap_h_v = 16'h5555;
    irq_in   = 1'b1;
    step(1);
    irq_in   = 1'b0;
    step(2);
    check("t4_in_rd_sl", {29'b0, avm_address}, 32'd4);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(3);
    check("t4_valid", {31'b0, tick_valid}, 32'd1);
    check("t4_snapshot", tick_snapshot, 32'h5555_AAAA);
    check("t4_wr_stop", bus_now(), bus(1'b1, 1'b0, 3'd1, 16'h0008));
    step(1);
    check("t4_idle", {30'b0, busy, running}, 32'd0);

    // 6: pending stop cleared, counter wraps, reset mid-read
    start  = 1'b1;
    period = 32'h0000_0100;
    step(1);
    start  = 1'b0;
    check("t6_wr_pl", bus_now(), bus(1'b1, 1'b0, 3'd2, 16'h0100));
    step(3);
    check("t6_armed", {29'b0, avm_chipselect, busy, running}, 32'd3);
    step(1);
    check("t6_still_armed", {29'b0, avm_chipselect, busy, running}, 32'd3);
    service("t6_svc1", 16'h0001, 16'h1000, 2'd1);
    service("t6_svc2", 16'h0002, 16'h2000, 2'd2);
    service("t6_svc3", 16'h0003, 16'h3000, 2'd3);
    service("t6_svc4", 16'h0004, 16'h4000, 2'd0);
    service("t6_svc5", 16'h0005, 16'h5000, 2'd1);
    irq_in = 1'b1;
    step(1);
    irq_in = 1'b0;
    step(4);
    check("t6_in_rd_sh", {29'b0, avm_address}, 32'd5);
    check("t6_rd_sh_cs", {31'b0, avm_chipselect}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_rst_cs", {31'b0, avm_chipselect}, 32'd0);
    check("t6_rst_count", {30'b0, tick_count}, 32'd0);
    check("t6_rst_flags", {29'b0, busy, running, tick_valid}, 32'd0);
    check("t6_rst_snap", tick_snapshot, 32'd0);
    step(1);
    reset_n = 1'b1;
    step(2);
    check("t6_post_rst", {30'b0, avm_chipselect, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
